// File: rtl/wb_hub_pkg.sv
// Shared types and constants for the wb_periph_hub Wishbone decoder slice.
package wb_hub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP,
    ST_ERR
  } hub_state_e;

  localparam logic [31:0] REG_IRQ_MASK    = 32'h0000_0000;
  localparam logic [31:0] REG_IRQ_STATUS  = 32'h0000_0004;
  localparam logic [31:0] REG_TIMEOUT_LOG = 32'h0000_0008;

  localparam int unsigned TO_FLAG_BIT = 31;

endpackage

// File: rtl/wb_hub_regs.sv
// Local IRQ mask/status/timeout-log registers and registered irq_o.
// Timeout flag and log exist only when WB_HUB_TIMEOUT_EN is defined.
module wb_hub_regs
  import wb_hub_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned OFF_W      = 12
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  acc_i,
  input  logic                  we_i,
  input  logic [3:0]            sel_i,
  input  logic [OFF_W-1:0]      off_i,
  input  logic [31:0]           dat_i,
  output logic [31:0]           rdat_o,
  input  logic [NUM_SLAVES-1:0] irq_i,
  output logic                  irq_o,
  input  logic                  to_set_i,
  input  logic [31:0]           to_adr_i
);

  localparam logic [31:0] MASK_VALID =
    (32'(1) << TO_FLAG_BIT) | ((32'(1) << NUM_SLAVES) - 32'd1);

  logic [31:0] mask_q, mask_d;
  logic [31:0] status_w;
  logic        irq_q;
  logic        wr_mask;
  logic        to_flag;
  logic [31:0] to_log;

  assign wr_mask = acc_i & we_i & (off_i == OFF_W'(REG_IRQ_MASK));

  always_comb begin
    mask_d = mask_q;
    if (wr_mask) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (sel_i[b]) mask_d[8*b +: 8] = dat_i[8*b +: 8] & MASK_VALID[8*b +: 8];
      end
    end
  end

`ifdef WB_HUB_TIMEOUT_EN
  logic        to_flag_q;
  logic [31:0] to_log_q;
  logic        to_clr;

  assign to_clr = acc_i & we_i & (off_i == OFF_W'(REG_IRQ_STATUS))
                & sel_i[TO_FLAG_BIT/8] & dat_i[TO_FLAG_BIT];

  // A timeout in the same cycle as a W1C keeps the flag set.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      to_flag_q <= 1'b0;
      to_log_q  <= '0;
    end else if (to_set_i) begin
      to_flag_q <= 1'b1;
      to_log_q  <= to_adr_i;
    end else if (to_clr) begin
      to_flag_q <= 1'b0;
    end
  end

  assign to_flag = to_flag_q;
  assign to_log  = to_log_q;
`else
  logic unused_to;
  assign unused_to = ^{to_set_i, to_adr_i};
  assign to_flag   = 1'b0;
  assign to_log    = '0;
`endif

  always_comb begin
    status_w                 = '0;
    status_w[NUM_SLAVES-1:0] = irq_i;
    status_w[TO_FLAG_BIT]    = to_flag;
  end

  always_comb begin
    rdat_o = '0;
    if (off_i == OFF_W'(REG_IRQ_MASK))         rdat_o = mask_q;
    else if (off_i == OFF_W'(REG_IRQ_STATUS))  rdat_o = status_w;
    else if (off_i == OFF_W'(REG_TIMEOUT_LOG)) rdat_o = to_log;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      irq_q  <= |(status_w & mask_q);
    end
  end

  assign irq_o = irq_q;

endmodule

// File: rtl/wb_periph_hub.sv
// Single-master Wishbone hub: window decode, registered slave request, local IRQ regs.
// Optional bus-timeout watchdog enabled by defining WB_HUB_TIMEOUT_EN.
module wb_periph_hub
  import wb_hub_pkg::*;
#(
  parameter int unsigned NUM_SLAVES     = 4,
  parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
  parameter int unsigned SPAN_BITS      = 12,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wbm_cyc_i,
  input  logic                     wbm_stb_i,
  input  logic                     wbm_we_i,
  input  logic [3:0]               wbm_sel_i,
  input  logic [31:0]              wbm_adr_i,
  input  logic [31:0]              wbm_dat_i,
  output logic                     wbm_ack_o,
  output logic                     wbm_err_o,
  output logic [31:0]              wbm_dat_o,
  output logic [NUM_SLAVES-1:0]    wbs_cyc_o,
  output logic [NUM_SLAVES-1:0]    wbs_stb_o,
  output logic                     wbs_we_o,
  output logic [3:0]               wbs_sel_o,
  output logic [31:0]              wbs_adr_o,
  output logic [31:0]              wbs_dat_o,
  input  logic [NUM_SLAVES-1:0]    wbs_ack_i,
  input  logic [32*NUM_SLAVES-1:0] wbs_dat_i,
  input  logic [NUM_SLAVES-1:0]    irq_i,
  output logic                     irq_o
);

  hub_state_e state_q, state_d;

  logic [NUM_SLAVES-1:0] wbs_stb_q;
  logic                  wbs_we_q;
  logic [3:0]            wbs_sel_q;
  logic [31:0]           wbs_adr_q, wbs_dat_q;
  logic                  wbm_ack_q, wbm_err_q;
  logic [31:0]           wbm_dat_q;

  logic        req, in_region, is_slave, is_local;
  logic [3:0]  slot_w;
  logic        ack_sel, timeout_w, reg_acc;
  logic [31:0] slave_rd, reg_rdat;

  assign req       = wbm_cyc_i & wbm_stb_i;
  assign slot_w    = 4'((wbm_adr_i - BASE_ADDR) >> SPAN_BITS);
  assign in_region = (wbm_adr_i[31:SPAN_BITS+4] == BASE_ADDR[31:SPAN_BITS+4]);
  assign is_slave  = in_region && ({28'd0, slot_w} < NUM_SLAVES);
  assign is_local  = in_region && ({28'd0, slot_w} == NUM_SLAVES);
  assign reg_acc   = (state_q == ST_IDLE) && req && is_local;

  // Only the strobed slot can complete the access; stray acks are masked out.
  assign ack_sel = |(wbs_ack_i & wbs_stb_q);

  always_comb begin
    slave_rd = '0;
    for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
      if (wbs_stb_q[k]) slave_rd = slave_rd | wbs_dat_i[32*k +: 32];
    end
  end

`ifdef WB_HUB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || state_q != ST_ACCESS) to_cnt_q <= '0;
    else                               to_cnt_q <= to_cnt_q + 1'b1;
  end

  assign timeout_w = (state_q == ST_ACCESS) && wbm_cyc_i && !ack_sel
                   && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout_w = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (is_slave)      state_d = ST_ACCESS;
          else if (is_local) state_d = ST_RESP;
          else               state_d = ST_ERR;
        end
      end
      ST_ACCESS: begin
        if (!wbm_cyc_i)     state_d = ST_IDLE;
        else if (ack_sel)   state_d = ST_RESP;
        else if (timeout_w) state_d = ST_ERR;
      end
      ST_RESP: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      wbs_stb_q <= '0;
      wbs_we_q  <= 1'b0;
      wbs_sel_q <= '0;
      wbs_adr_q <= '0;
      wbs_dat_q <= '0;
      wbm_ack_q <= 1'b0;
      wbm_err_q <= 1'b0;
      wbm_dat_q <= '0;
    end else begin
      state_q   <= state_d;
      wbm_ack_q <= (state_d == ST_RESP);
      wbm_err_q <= (state_d == ST_ERR);
      if (state_q == ST_IDLE && req) begin
        wbs_adr_q <= wbm_adr_i;
        wbs_dat_q <= wbm_dat_i;
        wbs_we_q  <= wbm_we_i;
        wbs_sel_q <= wbm_sel_i;
        if (is_local) wbm_dat_q <= reg_rdat;
      end
      if (state_q == ST_ACCESS && state_d == ST_RESP) wbm_dat_q <= slave_rd;
      if (state_d == ST_ERR) wbm_dat_q <= '0;
      if (state_q == ST_IDLE && state_d == ST_ACCESS) wbs_stb_q <= NUM_SLAVES'(1) << slot_w;
      else if (state_d != ST_ACCESS)                  wbs_stb_q <= '0;
    end
  end

  wb_hub_regs #(
    .NUM_SLAVES(NUM_SLAVES),
    .OFF_W     (SPAN_BITS)
  ) u_regs (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .acc_i   (reg_acc),
    .we_i    (wbm_we_i),
    .sel_i   (wbm_sel_i),
    .off_i   (wbm_adr_i[SPAN_BITS-1:0]),
    .dat_i   (wbm_dat_i),
    .rdat_o  (reg_rdat),
    .irq_i   (irq_i),
    .irq_o   (irq_o),
    .to_set_i(timeout_w),
    .to_adr_i(wbs_adr_q)
  );

  assign wbm_ack_o = wbm_ack_q;
  assign wbm_err_o = wbm_err_q;
  assign wbm_dat_o = wbm_dat_q;
  assign wbs_cyc_o = wbs_stb_q;
  assign wbs_stb_o = wbs_stb_q;
  assign wbs_we_o  = wbs_we_q;
  assign wbs_sel_o = wbs_sel_q;
  assign wbs_adr_o = wbs_adr_q;
  assign wbs_dat_o = wbs_dat_q;

endmodule

// File: tb/tb_wb_periph_hub.sv
// Directed bench for wb_periph_hub; timeout scenario adapts to WB_HUB_TIMEOUT_EN.
module tb_wb_periph_hub;

  localparam int unsigned NS = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_i;
  logic            wbm_cyc_i, wbm_stb_i, wbm_we_i;
  logic [3:0]      wbm_sel_i;
  logic [31:0]     wbm_adr_i, wbm_dat_i;
  logic            wbm_ack_o, wbm_err_o;
  logic [31:0]     wbm_dat_o;
  logic [NS-1:0]   wbs_cyc_o, wbs_stb_o;
  logic            wbs_we_o;
  logic [3:0]      wbs_sel_o;
  logic [31:0]     wbs_adr_o, wbs_dat_o;
  logic [NS-1:0]   wbs_ack_i;
  logic [32*NS-1:0] wbs_dat_i;
  logic [NS-1:0]   irq_i;
  logic            irq_o;

  int n_tests = 0;
  int n_fail  = 0;

  int            lat;
  logic          ga, ge;
  logic [31:0]   rd;
  logic [NS-1:0] ss;

  wb_periph_hub #(
    .NUM_SLAVES    (NS),
    .BASE_ADDR     (32'h3000_0000),
    .SPAN_BITS     (12),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i), .wbm_we_i(wbm_we_i),
    .wbm_sel_i(wbm_sel_i), .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i),
    .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o), .wbm_dat_o(wbm_dat_o),
    .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_we_o(wbs_we_o),
    .wbs_sel_o(wbs_sel_o), .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o),
    .wbs_ack_i(wbs_ack_i), .wbs_dat_i(wbs_dat_i),
    .irq_i(irq_i), .irq_o(irq_o)
  );

  // Master transaction with a slave model acking ack_dly cycles after its strobe;
  // non-selected slots get stray acks while waiting. lat counts negedges to response.
  task automatic xfer(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                      input logic [3:0] sel, input int ack_dly, input logic [31:0] sdat,
                      output int o_lat, output logic o_ack, output logic o_err,
                      output logic [31:0] o_rd, output logic [NS-1:0] o_stb);
    int scnt = 0;
    o_lat = 0; o_ack = 1'b0; o_err = 1'b0; o_rd = '0; o_stb = '0;
    @(negedge clk);
    wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1; wbm_we_i = we;
    wbm_sel_i = sel;  wbm_adr_i = adr;  wbm_dat_i = wdat;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      o_lat++;
      wbs_ack_i = '0;
      if (wbm_ack_o || wbm_err_o) begin
        o_ack = wbm_ack_o; o_err = wbm_err_o; o_rd = wbm_dat_o;
        break;
      end
      o_stb |= wbs_stb_o;
      if (wbs_stb_o != '0) begin
        if (scnt == ack_dly) begin
          wbs_ack_i = wbs_stb_o;
          for (int k = 0; k < NS; k++)
            wbs_dat_i[32*k +: 32] = wbs_stb_o[k] ? sdat : (32'hBAD0_0000 | 32'(k));
        end else begin
          wbs_ack_i = ~wbs_stb_o;
        end
        scnt++;
      end
    end
    wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0; wbs_ack_i = '0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({wbm_ack_o, wbm_err_o, wbm_dat_o, wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_sel_o,
         wbs_adr_o, wbs_dat_o, irq_o} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: ack=%b err=%b dat=%h cyc=%b stb=%b irq=%b, want all 0",
                         wbm_ack_o, wbm_err_o, wbm_dat_o, wbs_cyc_o, wbs_stb_o, irq_o);
    end
    rst_i = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({wbm_ack_o, wbm_err_o, wbs_stb_o} !== '0) begin
      n_fail++; $display("FAIL idle_after_reset: ack=%b err=%b stb=%b, want 0", wbm_ack_o, wbm_err_o, wbs_stb_o);
    end
  endtask

  task automatic test_slave_read();
    xfer(32'h3000_1004, 1'b0, 32'h0, 4'hF, 2, 32'hA5A5_0001, lat, ga, ge, rd, ss);
    n_tests++;
    if ({ga, ge} !== 2'b10 || lat != 4) begin
      n_fail++; $display("FAIL slave_read_ack: ack=%b err=%b lat=%0d, want ack=1 err=0 lat=4", ga, ge, lat);
    end
    n_tests++;
    if (rd !== 32'hA5A5_0001) begin
      n_fail++; $display("FAIL slave_read_data: got %h want a5a50001", rd);
    end
    n_tests++;
    if (ss !== 4'b0010) begin
      n_fail++; $display("FAIL slave_read_strobe: got %b want 0010", ss);
    end
    @(negedge clk);
    n_tests++;
    if (wbm_ack_o !== 1'b0 || wbs_adr_o !== 32'h3000_1004 || wbs_we_o !== 1'b0) begin
      n_fail++; $display("FAIL slave_read_after: ack=%b adr=%h we=%b, want 0 30001004 0", wbm_ack_o, wbs_adr_o, wbs_we_o);
    end
  endtask

  task automatic test_slave_write();
    xfer(32'h3000_3008, 1'b1, 32'h1234_5678, 4'b0110, 0, 32'h0000_CAFE, lat, ga, ge, rd, ss);
    n_tests++;
    if ({ga, ge} !== 2'b10 || lat != 2 || ss !== 4'b1000) begin
      n_fail++; $display("FAIL slave_write_ack: ack=%b err=%b lat=%0d stb=%b, want 1 0 2 1000", ga, ge, lat, ss);
    end
    n_tests++;
    if (wbs_dat_o !== 32'h1234_5678 || wbs_sel_o !== 4'b0110 || wbs_we_o !== 1'b1 || rd !== 32'h0000_CAFE) begin
      n_fail++; $display("FAIL slave_write_bus: dat=%h sel=%b we=%b rd=%h, want 12345678 0110 1 0000cafe",
                         wbs_dat_o, wbs_sel_o, wbs_we_o, rd);
    end
  endtask

  task automatic test_local_regs();
    xfer(32'h3000_4000, 1'b1, 32'hFFFF_FFFF, 4'hF, 0, 32'h0, lat, ga, ge, rd, ss);
    n_tests++;
    if ({ga, ge} !== 2'b10 || lat != 1 || ss !== '0) begin
      n_fail++; $display("FAIL local_write_ack: ack=%b err=%b lat=%0d stb=%b, want 1 0 1 0000", ga, ge, lat, ss);
    end
    xfer(32'h3000_4000, 1'b0, 32'h0, 4'hF, 0, 32'h0, lat, ga, ge, rd, ss);
    n_tests++;
    if (rd !== 32'h8000_000F) begin
      n_fail++; $display("FAIL mask_full_write: got %h want 8000000f", rd);
    end
    xfer(32'h3000_4000, 1'b1, 32'h0, 4'b1000, 0, 32'h0, lat, ga, ge, rd, ss);
    xfer(32'h3000_4000, 1'b0, 32'h0, 4'hF, 0, 32'h0, lat, ga, ge, rd, ss);
    n_tests++;
    if (rd !== 32'h0000_000F) begin
      n_fail++; $display("FAIL mask_byte_sel: got %h want 0000000f", rd);
    end
    xfer(32'h3000_400C, 1'b0, 32'h0, 4'hF, 0, 32'h0, lat, ga, ge, rd, ss);
    n_tests++;
    if (rd !== 32'h0 || ga !== 1'b1) begin
      n_fail++; $display("FAIL unmapped_offset: rd=%h ack=%b, want 0 1", rd, ga);
    end
  endtask

  task automatic test_irq();
    xfer(32'h3000_4000, 1'b1, 32'h0000_0005, 4'hF, 0, 32'h0, lat, ga, ge, rd, ss);
    n_tests++;
    if (ga !== 1'b1 || lat != 1) begin
      n_fail++; $display("FAIL irq_mask_write: ack=%b lat=%0d, want 1 1", ga, lat);
    end
    irq_i = 4'b0100;
    @(negedge clk);
    n_tests++;
    if (irq_o !== 1'b1) begin
      n_fail++; $display("FAIL irq_masked_on: got %b want 1", irq_o);
    end
    irq_i = 4'b0010;
    @(negedge clk);
    n_tests++;
    if (irq_o !== 1'b0) begin
      n_fail++; $display("FAIL irq_masked_off: got %b want 0", irq_o);
    end
    irq_i = 4'b0001;
    xfer(32'h3000_4004, 1'b0, 32'h0, 4'hF, 0, 32'h0, lat, ga, ge, rd, ss);
    n_tests++;
    if (rd !== 32'h0000_0001 || irq_o !== 1'b1) begin
      n_fail++; $display("FAIL irq_status_read: rd=%h irq=%b, want 00000001 1", rd, irq_o);
    end
    irq_i = '0;
  endtask

  task automatic test_decode_err();
    logic [31:0] addrs [3];
    addrs[0] = 32'h3000_6000; addrs[1] = 32'h4000_0000; addrs[2] = 32'h3000_5000;
    for (int a = 0; a < 3; a++) begin
      xfer(addrs[a], 1'b0, 32'h0, 4'hF, 0, 32'h0, lat, ga, ge, rd, ss);
      n_tests++;
      if ({ga, ge} !== 2'b01 || ss !== '0 || rd !== 32'h0 || lat != 1) begin
        n_fail++; $display("FAIL decode_err %h: ack=%b err=%b stb=%b rd=%h lat=%0d, want 0 1 0000 0 1",
                           addrs[a], ga, ge, ss, rd, lat);
      end
      @(negedge clk);
      n_tests++;
      if (wbm_err_o !== 1'b0) begin
        n_fail++; $display("FAIL decode_err_pulse %h: err=%b want 0", addrs[a], wbm_err_o);
      end
    end
  endtask

  task automatic test_timeout();
    xfer(32'h3000_2010, 1'b0, 32'h0, 4'hF, 1000, 32'h0, lat, ga, ge, rd, ss);
`ifdef WB_HUB_TIMEOUT_EN
    n_tests++;
    if ({ga, ge} !== 2'b01 || lat != 9 || ss !== 4'b0100) begin
      n_fail++; $display("FAIL timeout_err: ack=%b err=%b lat=%0d stb=%b, want 0 1 9 0100", ga, ge, lat, ss);
    end
    xfer(32'h3000_4004, 1'b0, 32'h0, 4'hF, 0, 32'h0, lat, ga, ge, rd, ss);
    n_tests++;
    if (rd !== 32'h8000_0000) begin
      n_fail++; $display("FAIL timeout_flag: got %h want 80000000", rd);
    end
    xfer(32'h3000_4008, 1'b0, 32'h0, 4'hF, 0, 32'h0, lat, ga, ge, rd, ss);
    n_tests++;
    if (rd !== 32'h3000_2010) begin
      n_fail++; $display("FAIL timeout_log: got %h want 30002010", rd);
    end
    xfer(32'h3000_4004, 1'b1, 32'h8000_0000, 4'hF, 0, 32'h0, lat, ga, ge, rd, ss);
    xfer(32'h3000_4004, 1'b0, 32'h0, 4'hF, 0, 32'h0, lat, ga, ge, rd, ss);
    n_tests++;
    if (rd !== 32'h0) begin
      n_fail++; $display("FAIL timeout_w1c: got %h want 0", rd);
    end
`else
    n_tests++;
    if ({ga, ge} !== 2'b00 || ss !== 4'b0100) begin
      n_fail++; $display("FAIL no_timeout_wait: ack=%b err=%b stb=%b, want 0 0 0100", ga, ge, ss);
    end
    @(negedge clk);
    n_tests++;
    if (wbs_stb_o !== '0) begin
      n_fail++; $display("FAIL no_timeout_abort: stb=%b want 0000", wbs_stb_o);
    end
    xfer(32'h3000_4004, 1'b0, 32'h0, 4'hF, 0, 32'h0, lat, ga, ge, rd, ss);
    n_tests++;
    if (rd !== 32'h0) begin
      n_fail++; $display("FAIL no_timeout_flag: got %h want 0", rd);
    end
    xfer(32'h3000_4008, 1'b0, 32'h0, 4'hF, 0, 32'h0, lat, ga, ge, rd, ss);
    n_tests++;
    if (rd !== 32'h0) begin
      n_fail++; $display("FAIL no_timeout_log: got %h want 0", rd);
    end
`endif
  endtask

  task automatic test_abort();
    @(negedge clk);
    wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1; wbm_we_i = 1'b0; wbm_adr_i = 32'h3000_0000;
    @(negedge clk);
    n_tests++;
    if (wbs_stb_o !== 4'b0001 || wbs_cyc_o !== 4'b0001) begin
      n_fail++; $display("FAIL abort_start: cyc=%b stb=%b want 0001", wbs_cyc_o, wbs_stb_o);
    end
    wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0;
    @(negedge clk);
    n_tests++;
    if (wbs_cyc_o !== '0 || wbs_stb_o !== '0) begin
      n_fail++; $display("FAIL abort_drop: cyc=%b stb=%b want 0000", wbs_cyc_o, wbs_stb_o);
    end
    wbs_ack_i = 4'b0001;
    @(negedge clk);
    wbs_ack_i = '0;
    n_tests++;
    if ({wbm_ack_o, wbm_err_o} !== 2'b00) begin
      n_fail++; $display("FAIL abort_late_ack: ack=%b err=%b want 0 0", wbm_ack_o, wbm_err_o);
    end
    @(negedge clk);
    n_tests++;
    if ({wbm_ack_o, wbm_err_o} !== 2'b00) begin
      n_fail++; $display("FAIL abort_quiet: ack=%b err=%b want 0 0", wbm_ack_o, wbm_err_o);
    end
    xfer(32'h3000_0000, 1'b0, 32'h0, 4'hF, 1, 32'h1111_2222, lat, ga, ge, rd, ss);
    n_tests++;
    if ({ga, ge} !== 2'b10 || lat != 3 || rd !== 32'h1111_2222) begin
      n_fail++; $display("FAIL abort_next: ack=%b err=%b lat=%0d rd=%h, want 1 0 3 11112222", ga, ge, lat, rd);
    end
  endtask

  task automatic test_reset_mid();
    xfer(32'h3000_4000, 1'b1, 32'h0000_000F, 4'hF, 0, 32'h0, lat, ga, ge, rd, ss);
    irq_i = 4'b0010;
    @(negedge clk);
    wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1; wbm_we_i = 1'b1;
    wbm_adr_i = 32'h3000_3000; wbm_dat_i = 32'hFFFF_FFFF; wbm_sel_i = 4'hF;
    @(negedge clk);
    n_tests++;
    if (wbs_stb_o !== 4'b1000 || irq_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_setup: stb=%b irq=%b want 1000 1", wbs_stb_o, irq_o);
    end
    rst_i = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({wbm_ack_o, wbm_err_o, wbm_dat_o, wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_sel_o,
         wbs_adr_o, wbs_dat_o, irq_o} !== '0) begin
      n_fail++; $display("FAIL reset_mid_outputs: ack=%b stb=%b we=%b adr=%h dat=%h irq=%b, want all 0",
                         wbm_ack_o, wbs_stb_o, wbs_we_o, wbs_adr_o, wbs_dat_o, irq_o);
    end
    rst_i = 1'b0; wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({wbm_ack_o, irq_o} !== 2'b00) begin
      n_fail++; $display("FAIL reset_mid_noack: ack=%b irq=%b want 0 0", wbm_ack_o, irq_o);
    end
    xfer(32'h3000_4000, 1'b0, 32'h0, 4'hF, 0, 32'h0, lat, ga, ge, rd, ss);
    n_tests++;
    if (rd !== 32'h0) begin
      n_fail++; $display("FAIL reset_mid_mask: got %h want 0", rd);
    end
    irq_i = '0;
  endtask

  initial begin
    rst_i = 1'b1; wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0; wbm_we_i = 1'b0;
    wbm_sel_i = '0; wbm_adr_i = '0; wbm_dat_i = '0;
    wbs_ack_i = '0; wbs_dat_i = '0; irq_i = '0;
    test_reset();
    test_slave_read();
    test_slave_write();
    test_local_regs();
    test_irq();
    test_decode_err();
    test_timeout();
    test_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wb_periph_hub.md
Name: wb_periph_hub

Overview:
- Parametrised single-master Wishbone hub that replaces hand-written per-subsystem decoders.
- Decodes a contiguous address region into NUM_SLAVES equal windows and registers the request toward the selected slave.
- Returns ack or error to the master.
- Aggregates slave interrupts behind a local mask/status register window, and optionally a bus-timeout watchdog.

Parameters:
- NUM_SLAVES, 4, number of slave windows (1..15).
- BASE_ADDR, 32'h3000_0000, region base; must be aligned to SLAVE_SPAN*16.
- SPAN_BITS, 12, log2 of window size in bytes (window = 4 KiB).
- TIMEOUT_CYCLES, 255, ACCESS-state cycles before a bus error (used only with WB_HUB_TIMEOUT_EN).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- wbm_cyc_i  in  1  master cycle
- wbm_stb_i  in  1  master strobe
- wbm_we_i  in  1  master write enable
- wbm_sel_i  in  4  master byte selects
- wbm_adr_i  in  32  master address
- wbm_dat_i  in  32  master write data
- wbm_ack_o  out  1  master ack
- wbm_err_o  out  1  master bus error
- wbm_dat_o  out  32  master read data
- wbs_cyc_o  out  NUM_SLAVES  per-slave cycle
- wbs_stb_o  out  NUM_SLAVES  per-slave strobe
- wbs_we_o  out  1  shared write enable
- wbs_sel_o  out  4  shared byte selects
- wbs_adr_o  out  32  shared address
- wbs_dat_o  out  32  shared write data
- wbs_ack_i  in  NUM_SLAVES  per-slave ack
- wbs_dat_i  in  32*NUM_SLAVES  slave read data; slot k at [32k+31:32k]
- irq_i  in  NUM_SLAVES  level interrupts from slaves
- irq_o  out  1  aggregated masked interrupt

Behaviour:
- Reset values: wbm_ack_o=0, wbm_err_o=0, wbm_dat_o=0, wbs_cyc_o=0, wbs_stb_o=0, wbs_we_o=0, wbs_sel_o=0, wbs_adr_o=0, wbs_dat_o=0, irq_o=0, IRQ_MASK=0, IRQ_STATUS sticky bits=0, TIMEOUT_LOG=0, FSM=IDLE.
- Decode:
  - slot = (wbm_adr_i - BASE_ADDR) >> SPAN_BITS.
  - In region means wbm_adr_i[31:SPAN_BITS+4] == BASE_ADDR[31:SPAN_BITS+4].
  - slot < NUM_SLAVES -> slave; slot == NUM_SLAVES -> local registers; otherwise, or out of region -> error.
- FSM states: IDLE, ACCESS, RESP, ERR.
- IDLE:
  - On wbm_cyc_i & wbm_stb_i, latch adr/dat/we/sel into the wbs_* outputs.
  - Slave slot -> ACCESS, with wbs_cyc_o[slot]=wbs_stb_o[slot]=1 from the next cycle.
  - Local -> RESP, with register read/write performed this cycle.
  - Error -> ERR.
- ACCESS:
  - On wbs_ack_i[slot]: capture wbs_dat_i slot into wbm_dat_o, drop wbs_cyc/stb, go to RESP.
  - Acks from non-selected slots are ignored.
- RESP: wbm_ack_o=1 for exactly one cycle, then IDLE.
- ERR: wbm_err_o=1 for one cycle, wbm_dat_o=0, then IDLE.
- Latency:
  - Local access: ack 2 cycles after strobe.
  - Slave access: ack the cycle after slave ack, so minimum 3 cycles.
  - Master holds stb until ack/err; one outstanding transaction only.
- Abort: wbm_cyc_i low in ACCESS -> wbs_cyc/stb low next cycle, IDLE, no ack/err.
- Local registers (byte offset within local window):
  - 0x0 IRQ_MASK (RW): bits [NUM_SLAVES-1:0] plus bit31.
  - 0x4 IRQ_STATUS:
    - Read returns irq_i in the low bits and sticky timeout flag in bit31.
    - Write 1 to bit31 clears it; low bits ignore writes.
  - 0x8 TIMEOUT_LOG (RO): address of the last timed-out access.
  - Other offsets read 0; writes ignored.
  - wbm_sel_i applies per byte to RW registers.
- irq_o registered: |(IRQ_STATUS & IRQ_MASK), 1-cycle latency from irq_i.
- If a timeout and a W1C of bit31 occur in the same cycle, set wins.
- rst_i mid-transaction: all outputs return to reset values next edge; no ack issued.

Optional Feature:
- WB_HUB_TIMEOUT_EN defined:
  - 8-bit+ counter (width clog2(TIMEOUT_CYCLES+1)) clears on ACCESS entry and increments each ACCESS cycle.
  - When it reaches TIMEOUT_CYCLES without ack: drop wbs_cyc/stb, go to ERR, set IRQ_STATUS[31], load TIMEOUT_LOG with the latched address.
- Undefined: ACCESS waits indefinitely, IRQ_STATUS[31] and TIMEOUT_LOG read 0, no counter logic.

Decomposition:
- Package wb_hub_pkg holds:
  - FSM state enum.
  - Local register offsets (0x0, 0x4, 0x8).
  - TIMEOUT flag bit index 31.
- One natural sub-module: wb_hub_regs (IRQ mask/status/log registers and irq_o generation); the FSM/decoder stays in the top.

Test Plan:
- Read slot 1 (adr 0x3000_1004), slave acks 2 cycles after wbs_stb_o with 0xA5A5_0001 -> wbs_stb_o[1] only; wbm_ack_o one cycle later; wbm_dat_o=0xA5A5_0001.
- Write 0x0000_0005 to IRQ_MASK (0x3000_4000, NUM_SLAVES=4); drive irq_i=4'b0100 -> ack 2 cycles after strobe; irq_o=1 one cycle after irq_i; irq_i=4'b0010 -> irq_o=0.
- Access 0x3000_6000 and 0x4000_0000 -> wbm_err_o one cycle, no wbs_stb_o asserted, wbm_ack_o stays 0.
- With WB_HUB_TIMEOUT_EN and TIMEOUT_CYCLES=8, slot 2 never acks:
  - wbm_err_o after 8 ACCESS cycles; TIMEOUT_LOG=access address; IRQ_STATUS[31]=1.
  - Write 0x8000_0000 to IRQ_STATUS -> bit clears.
- Master drops wbm_cyc_i in ACCESS, then a late slave ack arrives -> wbs_cyc_o low next cycle; no master ack; next transaction completes normally.
- Assert rst_i during ACCESS -> all outputs 0 next edge; IRQ_MASK=0.
